// File: rtl/bist_pattern_driver.sv
// LFSR stimulus generator and MISR response compactor for self-testing a combinational CUT.
// Optional BIST_COMPARE_EN adds a golden input and a registered pass flag.
module bist_pattern_driver #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      CNT_W      = 16,
  parameter int unsigned      N_PATTERNS = 1000,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(32'h1),
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(32'h80200003)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] cut_in,
  input  logic [WIDTH-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
`ifdef BIST_COMPARE_EN
  input  logic [WIDTH-1:0] golden,
`endif
  output logic             pass
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_LOAD = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] misr;
  logic [WIDTH-1:0] misr_next;
  logic [WIDTH-1:0] misr_step;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             busy_next;
  logic             done_next;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] r);
    return {r[WIDTH-2:0], ^(r & POLY)};
  endfunction

  // Compaction of the vector currently applied to the CUT.
  assign misr_step = step(misr) ^ cut_out;

  assign cut_in    = lfsr;
  assign signature = misr;

`ifdef BIST_COMPARE_EN
  logic pass_q;
  logic pass_next;
  assign pass = pass_q;
`else
  assign pass = 1'b0;
`endif

  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    misr_next  = misr;
    count_next = count;
`ifdef BIST_COMPARE_EN
    pass_next  = pass_q;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          lfsr_next  = SEED_LOAD;
          misr_next  = '0;
          count_next = '0;
`ifdef BIST_COMPARE_EN
          pass_next  = 1'b0;
`endif
        end
      end
      RUN: begin
        // abort wins over the terminal count and suppresses compaction.
        if (abort) begin
          state_next = IDLE;
        end else begin
          misr_next  = misr_step;
          lfsr_next  = step(lfsr);
          count_next = count + CNT_W'(1);
          if (count == LAST_CNT) begin
            state_next = DONE;
`ifdef BIST_COMPARE_EN
            pass_next  = (misr_step == golden);
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lfsr   <= SEED_LOAD;
      misr   <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef BIST_COMPARE_EN
      pass_q <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      lfsr   <= lfsr_next;
      misr   <= misr_next;
      count  <= count_next;
      busy   <= busy_next;
      done   <= done_next;
`ifdef BIST_COMPARE_EN
      pass_q <= pass_next;
`endif
    end
  end

endmodule

// File: tb/tb_bist_pattern_driver.sv
// Randomized scoreboard bench for bist_pattern_driver (WIDTH=4, POLY=4'h9, SEED=4'h1).
// Two instances: N_PATTERNS=3 with a random combinational CUT, N_PATTERNS=15 with a zero CUT.
module tb_bist_pattern_driver;

`ifdef BIST_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] cut_in3;
  logic [3:0] cut_out3;
  logic [3:0] sig3;
  logic       busy3;
  logic       done3;
  logic       pass3;
  logic [3:0] cut_k;
  logic [3:0] cut_mask;

  logic       start15;
  logic       abort15;
  logic [3:0] cut_in15;
  logic [3:0] cut_out15;
  logic [3:0] sig15;
  logic       busy15;
  logic       done15;
  logic       pass15;

`ifdef BIST_COMPARE_EN
  logic [3:0] golden3;
  logic [3:0] golden15;
`endif

  // Random combinational CUT: multiply-and-xor of the applied vector.
  assign cut_out3 = 4'((cut_in3 * cut_k) ^ cut_mask);

  bist_pattern_driver #(
    .WIDTH(4), .CNT_W(8), .N_PATTERNS(3), .SEED(4'h1), .POLY(4'h9)
  ) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cut_in(cut_in3), .cut_out(cut_out3), .busy(busy3), .done(done3),
    .signature(sig3),
`ifdef BIST_COMPARE_EN
    .golden(golden3),
`endif
    .pass(pass3)
  );

  bist_pattern_driver #(
    .WIDTH(4), .CNT_W(8), .N_PATTERNS(15), .SEED(4'h1), .POLY(4'h9)
  ) u_dut15 (
    .clk(clk), .rst(rst), .start(start15), .abort(abort15),
    .cut_in(cut_in15), .cut_out(cut_out15), .busy(busy15), .done(done15),
    .signature(sig15),
`ifdef BIST_COMPARE_EN
    .golden(golden15),
`endif
    .pass(pass15)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] sig;
    logic       pass;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Reference: left-shift register with parity-of-taps feedback.
  function automatic logic [3:0] stp(input logic [3:0] r);
    logic [3:0] t;
    t = r & 4'h9;
    return {r[2:0], t[3] ^ t[2] ^ t[1] ^ t[0]};
  endfunction

  function automatic logic [3:0] model_vec(input int i);
    logic [3:0] v;
    v = 4'h1;
    for (int j = 0; j < i; j++) v = stp(v);
    return v;
  endfunction

  function automatic logic [3:0] model_sig(input int n, input logic [3:0] k, input logic [3:0] m);
    logic [3:0] s;
    logic [3:0] v;
    s = 4'h0;
    for (int j = 0; j < n; j++) begin
      v = model_vec(j);
      s = stp(s) ^ 4'((v * k) ^ m);
    end
    return s;
  endfunction

  // Monitor: every rising done on the N=3 instance pops one expected result.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done3 && !done_prev) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          mon_e = sbq.pop_front();
          check("signature", 32'(sig3), 32'(mon_e.sig));
          check("pass", 32'(pass3), 32'(mon_e.pass));
        end
      end
      done_prev = done3;
    end
  end

  // One run on the N=3 instance; abort_at<0 means run to completion.
  task automatic run3(input int abort_at, input bit hold, input logic [3:0] gold);
    exp_t       e;
    logic [3:0] full;
    full = model_sig(3, cut_k, cut_mask);
`ifdef BIST_COMPARE_EN
    golden3 = gold;
`endif
    if (abort_at < 0) begin
      e.sig  = full;
      e.pass = CMP && (gold == full);
      sbq.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("busy_run", 32'(busy3), 32'(1));
      check("cut_in_run", 32'(cut_in3), 32'(model_vec(i)));
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy3), 32'(0));
        check("abort_done", 32'(done3), 32'(0));
        check("abort_sig", 32'(sig3), 32'(model_sig(i, cut_k, cut_mask)));
        return;
      end
      @(negedge clk);
    end
    check("done_rise", 32'(done3), 32'(1));
    check("done_busy", 32'(busy3), 32'(0));
    check("done_cut_in", 32'(cut_in3), 32'(model_vec(3)));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int         ab;
    logic [3:0] g;
    logic [15:0] seen;
    int         nbusy;
    int         dup;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start15 = 1'b0; abort15 = 1'b0; cut_out15 = 4'h0;
    cut_k = 4'h1; cut_mask = 4'h0;
`ifdef BIST_COMPARE_EN
    golden3 = 4'h0; golden15 = 4'h0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy3), 32'(0));
    check("rst_done", 32'(done3), 32'(0));
    check("rst_cut_in", 32'(cut_in3), 32'(1));
    check("rst_sig", 32'(sig3), 32'(0));
    check("rst_pass", 32'(pass3), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Loopback, good then bad golden.
    run3(-1, 1'b0, 4'h7);
    check("loop_sig_7", 32'(sig3), 32'(4'h7));
    @(negedge clk);
    check("done_hold", 32'(done3), 32'(1));
    run3(-1, 1'b0, 4'h6);
    @(negedge clk);

    // Abort on the second RUN cycle, then a clean rerun.
    run3(1, 1'b0, 4'h7);
    check("abort_sig_1", 32'(sig3), 32'(4'h1));
    run3(-1, 1'b0, 4'h7);
    @(negedge clk);

    // start held high straight through DONE.
    run3(-1, 1'b1, 4'h7);
    run3(-1, 1'b0, 4'h7);
    check("rerun_sig_7", 32'(sig3), 32'(4'h7));
    @(negedge clk);

    // Reset in the middle of a run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy3), 32'(0));
    check("midrst_done", 32'(done3), 32'(0));
    check("midrst_cut_in", 32'(cut_in3), 32'(1));
    check("midrst_sig", 32'(sig3), 32'(0));
    check("midrst_pass", 32'(pass3), 32'(0));
    @(negedge clk);

    // Random CUTs, aborts, hold and golden values.
    for (int r = 0; r < 16; r++) begin
      cut_k    = 4'($urandom);
      cut_mask = 4'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
      g  = ($urandom_range(0, 1) == 0) ? model_sig(3, cut_k, cut_mask) : 4'($urandom);
      run3(ab, 1'($urandom_range(0, 1)), g);
    end
    start = 1'b0;
    @(negedge clk);

    // Zero CUT over a full LFSR period.
    start15 = 1'b1;
    @(negedge clk);
    start15 = 1'b0;
    seen = 16'h0; nbusy = 0; dup = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy15) begin
        nbusy++;
        if (seen[cut_in15]) dup++;
        seen[cut_in15] = 1'b1;
      end
      if (done15) break;
      @(negedge clk);
    end
    check("p15_done", 32'(done15), 32'(1));
    check("p15_busy_cycles", 32'(nbusy), 32'(15));
    check("p15_states", 32'(seen), 32'(16'hFFFE));
    check("p15_dups", 32'(dup), 32'(0));
    check("p15_sig", 32'(sig15), 32'(0));
    check("p15_pass", 32'(pass15), 32'(CMP));

    @(negedge clk);
    check("sb_empty", 32'(sbq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
